// File: rtl/gecmisli_ongorucu_if.sv
// gecmisli_ongorucu_if: fetch/execute bus between the pipeline and the branch predictor.
interface gecmisli_ongorucu_if #(
  parameter int GECMIS_BIT = 8
);
  logic [31:0]           getir_ps;
  logic [31:0]           getir_buyruk;
  logic                  getir_gecerli;
  logic [31:0]           yurut_ps;
  logic [GECMIS_BIT-1:0] yurut_gecmis;
  logic                  yurut_dallan;
  logic                  yurut_yanlis;
  logic                  yurut_gecerli;
  logic                  hazir;
  logic                  sonuc_gecerli;
  logic                  sonuc_dallan;
  logic [31:0]           sonuc_dallan_ps;
  logic [GECMIS_BIT-1:0] sonuc_gecmis;
  logic [31:0]           yanlis_sayaci;
  modport master (
    output getir_ps, getir_buyruk, getir_gecerli,
    output yurut_ps, yurut_gecmis, yurut_dallan, yurut_yanlis, yurut_gecerli,
    input  hazir, sonuc_gecerli, sonuc_dallan, sonuc_dallan_ps, sonuc_gecmis, yanlis_sayaci
  );
  modport slave (
    input  getir_ps, getir_buyruk, getir_gecerli,
    input  yurut_ps, yurut_gecmis, yurut_dallan, yurut_yanlis, yurut_gecerli,
    output hazir, sonuc_gecerli, sonuc_dallan, sonuc_dallan_ps, sonuc_gecmis, yanlis_sayaci
  );
endinterface

// File: rtl/gecmisli_ongorucu.sv
// gecmisli_ongorucu: bimodal/gshare branch predictor with speculative global history and recovery.
module gecmisli_ongorucu #(
  parameter int TABLO_BIT  = 10,
  parameter int SAYAC_BIT  = 2,
  parameter int GECMIS_BIT = 8,
  parameter int MOD        = 1
) (
  input  logic                clk,
  input  logic                rst,
  gecmisli_ongorucu_if.slave  bus
);
  localparam int N = 2 ** TABLO_BIT;
  localparam logic [SAYAC_BIT-1:0] ZAYIF = SAYAC_BIT'(2 ** (SAYAC_BIT - 1) - 1);
  localparam logic [SAYAC_BIT-1:0] DOYMA = '1;
  typedef enum logic {TEMIZLE, HAZIR} durum_t;
  durum_t                r_durum, w_durum;
  logic [TABLO_BIT-1:0]  r_k;
  logic [SAYAC_BIT-1:0]  r_tablo [N];
  logic [GECMIS_BIT-1:0] r_ghr, r_gecmis;
  logic                  r_sg, r_dallan;
  logic [31:0]           r_hedef, r_yanlis;
  logic                  w_hazir, w_ara, w_gun, w_kurtar, w_dal_mi, w_tahmin, w_yaz;
  logic [TABLO_BIT-1:0]  w_idx, w_uidx, w_yaz_adr;
  logic [SAYAC_BIT-1:0]  w_eski, w_yeni, w_yaz_veri;
  logic [31:0]           w_imm;
  assign w_hazir  = r_durum == HAZIR;
  assign w_ara    = w_hazir & bus.getir_gecerli;
  assign w_gun    = w_hazir & bus.yurut_gecerli;
  assign w_kurtar = w_gun & bus.yurut_yanlis;
  assign w_idx    = bus.getir_ps[TABLO_BIT+1:2] ^ (MOD != 0 ? TABLO_BIT'(r_ghr) : '0);
  assign w_uidx   = bus.yurut_ps[TABLO_BIT+1:2] ^ (MOD != 0 ? TABLO_BIT'(bus.yurut_gecmis) : '0);
  assign w_dal_mi = bus.getir_buyruk[6:0] == 7'b1100011;
  assign w_tahmin = w_dal_mi & r_tablo[w_idx][SAYAC_BIT-1];
  assign w_imm    = {{20{bus.getir_buyruk[31]}}, bus.getir_buyruk[7], bus.getir_buyruk[30:25],
                     bus.getir_buyruk[11:8], 1'b0};
  assign w_eski   = r_tablo[w_uidx];
  assign w_yeni   = bus.yurut_dallan ? (w_eski == DOYMA ? w_eski : w_eski + SAYAC_BIT'(1))
                                     : (w_eski == '0 ? w_eski : w_eski - SAYAC_BIT'(1));
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_durum <= TEMIZLE;
      r_k     <= '0;
    end else begin
      r_durum <= w_durum;
      r_k     <= r_durum == TEMIZLE ? r_k + TABLO_BIT'(1) : '0;
    end
  // Init sweep owns the single write port; resolves only write once the table is clean.
  always_comb begin
    w_durum    = r_durum;
    w_yaz      = w_gun;
    w_yaz_adr  = w_uidx;
    w_yaz_veri = w_yeni;
    if (r_durum == TEMIZLE) begin
      w_yaz      = 1'b1;
      w_yaz_adr  = r_k;
      w_yaz_veri = ZAYIF;
      w_durum    = r_k == '1 ? HAZIR : TEMIZLE;
    end
  end
  always_ff @(posedge clk)
    if (w_yaz) r_tablo[w_yaz_adr] <= w_yaz_veri;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_sg     <= 1'b0;
      r_dallan <= 1'b0;
      r_hedef  <= '0;
      r_gecmis <= '0;
      r_ghr    <= '0;
      r_yanlis <= '0;
    end else begin
      r_sg <= w_ara;
      if (w_ara) begin
        r_dallan <= w_tahmin;
        r_hedef  <= bus.getir_ps + (w_tahmin ? w_imm : 32'd4);
        r_gecmis <= r_ghr;
      end
      if (w_kurtar) r_ghr <= GECMIS_BIT'({bus.yurut_gecmis, bus.yurut_dallan});
      else if (w_ara & w_dal_mi) r_ghr <= GECMIS_BIT'({r_ghr, w_tahmin});
      if (w_kurtar) r_yanlis <= r_yanlis + 32'd1;
    end
  assign bus.hazir           = w_hazir;
  assign bus.sonuc_gecerli   = r_sg;
  assign bus.sonuc_dallan    = r_dallan;
  assign bus.sonuc_dallan_ps = r_hedef;
  assign bus.sonuc_gecmis    = r_gecmis;
  assign bus.yanlis_sayaci   = r_yanlis;
endmodule

// File: tb/tb_gecmisli_ongorucu.sv
// tb_gecmisli_ongorucu: directed checks of a bimodal (bi) and a gshare (gi) predictor instance.
module tb_gecmisli_ongorucu;
  localparam logic [31:0] BEQ = 32'hFE000CE3;
  localparam logic [31:0] NOP = 32'h00000013;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] ps, buyruk, yps;
  logic [7:0]  ygecmis;
  logic        gg, yg, ydallan, yyanlis;
  logic [1:0]  sec;
  int          n_vec = 0;
  int          n_hata = 0;
  always #5 clk = ~clk;
  gecmisli_ongorucu_if #(.GECMIS_BIT(8)) bi ();
  gecmisli_ongorucu_if #(.GECMIS_BIT(8)) gi ();
  // sec: 0 = bimodal only, 1 = gshare only, 2 = both see valid requests
  assign bi.getir_ps      = ps;
  assign bi.getir_buyruk  = buyruk;
  assign bi.getir_gecerli = gg & (sec != 2'd1);
  assign bi.yurut_ps      = yps;
  assign bi.yurut_gecmis  = ygecmis;
  assign bi.yurut_dallan  = ydallan;
  assign bi.yurut_yanlis  = yyanlis;
  assign bi.yurut_gecerli = yg & (sec != 2'd1);
  assign gi.getir_ps      = ps;
  assign gi.getir_buyruk  = buyruk;
  assign gi.getir_gecerli = gg & (sec != 2'd0);
  assign gi.yurut_ps      = yps;
  assign gi.yurut_gecmis  = ygecmis;
  assign gi.yurut_dallan  = ydallan;
  assign gi.yurut_yanlis  = yyanlis;
  assign gi.yurut_gecerli = yg & (sec != 2'd0);
  gecmisli_ongorucu #(.MOD(0)) u_bi (.clk(clk), .rst(rst), .bus(bi.slave));
  gecmisli_ongorucu #(.MOD(1)) u_gi (.clk(clk), .rst(rst), .bus(gi.slave));
  task automatic denetle(input string etiket, input logic [31:0] gercek, input logic [31:0] beklenen);
    n_vec++;
    if (gercek !== beklenen) begin
      n_hata++;
      $display("FAIL %s: got %h, want %h", etiket, gercek, beklenen);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic ara(input logic [31:0] p, input logic [31:0] b);
    gg = 1'b1;
    ps = p;
    buyruk = b;
    cyc();
    gg = 1'b0;
  endtask
  task automatic guncelle(input logic [31:0] p, input logic [7:0] g, input logic d, input logic y);
    yg = 1'b1;
    yps = p;
    ygecmis = g;
    ydallan = d;
    yyanlis = y;
    cyc();
    yg = 1'b0;
    yyanlis = 1'b0;
  endtask
  task automatic init_bekle();
    int erken = 0;
    for (int j = 1; j <= 1024; j++) begin
      cyc();
      if (j < 1024 && (bi.hazir || gi.hazir || bi.sonuc_gecerli || gi.sonuc_gecerli)) erken++;
    end
    denetle("init_early", erken, 0);
    denetle("init_hazir_bi", bi.hazir, 1);
    denetle("init_hazir_gi", gi.hazir, 1);
    denetle("init_sg", {bi.sonuc_gecerli, gi.sonuc_gecerli}, 0);
    denetle("init_yanlis", gi.yanlis_sayaci, 0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end
  initial begin
    ps = 32'h100; buyruk = BEQ; gg = 1'b1;
    yps = 32'h100; ygecmis = 8'h55; ydallan = 1'b1; yyanlis = 1'b1; yg = 1'b1; sec = 2'd2;
    cyc();
    cyc();
    denetle("rst_hazir", {bi.hazir, gi.hazir}, 0);
    denetle("rst_sg", {bi.sonuc_gecerli, gi.sonuc_gecerli}, 0);
    denetle("rst_ps", gi.sonuc_dallan_ps, 0);
    denetle("rst_yanlis", gi.yanlis_sayaci, 0);
    rst = 1'b1;
    init_bekle();
    yg = 1'b0; yyanlis = 1'b0;
    cyc();
    denetle("a_sg", {bi.sonuc_gecerli, gi.sonuc_gecerli}, 2'b11);
    denetle("a_dallan", {bi.sonuc_dallan, gi.sonuc_dallan}, 0);
    denetle("a_ps_bi", bi.sonuc_dallan_ps, 32'h104);
    denetle("a_ps_gi", gi.sonuc_dallan_ps, 32'h104);
    denetle("a_gecmis", gi.sonuc_gecmis, 0);
    gg = 1'b0;
    cyc();
    denetle("hold_sg", gi.sonuc_gecerli, 0);
    denetle("hold_ps", gi.sonuc_dallan_ps, 32'h104);
    sec = 2'd0;
    repeat (2) guncelle(32'h100, 8'h00, 1'b1, 1'b0);
    ara(32'h100, BEQ);
    denetle("b_dallan", bi.sonuc_dallan, 1);
    denetle("b_ps", bi.sonuc_dallan_ps, 32'h0F8);
    ara(32'h100, NOP);
    denetle("b_nop_dallan", bi.sonuc_dallan, 0);
    denetle("b_nop_ps", bi.sonuc_dallan_ps, 32'h104);
    repeat (5) guncelle(32'h100, 8'h00, 1'b1, 1'b0);
    guncelle(32'h100, 8'h00, 1'b0, 1'b0);
    ara(32'h100, BEQ);
    denetle("b_sat_dallan", bi.sonuc_dallan, 1);
    denetle("b_sat_ps", bi.sonuc_dallan_ps, 32'h0F8);
    guncelle(32'h100, 8'h00, 1'b0, 1'b0);
    ara(32'h100, BEQ);
    denetle("b_down_dallan", bi.sonuc_dallan, 0);
    sec = 2'd1;
    repeat (2) guncelle(32'h200, 8'h01, 1'b1, 1'b0);
    ara(32'h200, BEQ);
    denetle("c_80_dallan", gi.sonuc_dallan, 0);
    denetle("c_80_gecmis", gi.sonuc_gecmis, 8'h00);
    ara(32'h204, BEQ);
    denetle("c_81_dallan", gi.sonuc_dallan, 1);
    denetle("c_81_ps", gi.sonuc_dallan_ps, 32'h1FC);
    ara(32'h200, BEQ);
    denetle("c_g1_dallan", gi.sonuc_dallan, 1);
    denetle("c_g1_ps", gi.sonuc_dallan_ps, 32'h1F8);
    denetle("c_g1_gecmis", gi.sonuc_gecmis, 8'h01);
    ara(32'h208, BEQ);
    denetle("c_g3_gecmis", gi.sonuc_gecmis, 8'h03);
    gg = 1'b1; ps = 32'h218; buyruk = BEQ;
    yg = 1'b1; yps = 32'h300; ygecmis = 8'h00; ydallan = 1'b0; yyanlis = 1'b1;
    cyc();
    gg = 1'b0; yg = 1'b0; yyanlis = 1'b0;
    denetle("d_dallan", gi.sonuc_dallan, 1);
    denetle("d_ps", gi.sonuc_dallan_ps, 32'h210);
    denetle("d_gecmis", gi.sonuc_gecmis, 8'h07);
    denetle("d_yanlis", gi.yanlis_sayaci, 1);
    ara(32'h200, BEQ);
    denetle("d_ghr", gi.sonuc_gecmis, 8'h00);
    denetle("d_yanlis_bi", bi.yanlis_sayaci, 0);
    gg = 1'b1; ps = 32'h200; buyruk = BEQ;
    yg = 1'b1; yps = 32'h200; ygecmis = 8'h00; ydallan = 1'b1;
    cyc();
    gg = 1'b0; yg = 1'b0;
    denetle("e_old", gi.sonuc_dallan, 0);
    ara(32'h200, BEQ);
    denetle("e_new", gi.sonuc_dallan, 1);
    denetle("e_ps", gi.sonuc_dallan_ps, 32'h1F8);
    sec = 2'd2;
    gg = 1'b1; ps = 32'h100; buyruk = BEQ;
    yg = 1'b1; yps = 32'h204; ygecmis = 8'h00; ydallan = 1'b1; yyanlis = 1'b1;
    rst = 1'b0;
    #1;
    denetle("f_rst_ps", gi.sonuc_dallan_ps, 0);
    denetle("f_rst_yanlis", gi.yanlis_sayaci, 0);
    denetle("f_rst_dallan", gi.sonuc_dallan, 0);
    cyc();
    rst = 1'b1;
    repeat (500) cyc();
    rst = 1'b0;
    #1;
    denetle("f_mid_hazir", {bi.hazir, gi.hazir}, 0);
    cyc();
    rst = 1'b1;
    init_bekle();
    yg = 1'b0; yyanlis = 1'b0;
    ara(32'h204, BEQ);
    denetle("f_81_dallan", gi.sonuc_dallan, 0);
    denetle("f_81_ps", gi.sonuc_dallan_ps, 32'h208);
    ara(32'h200, BEQ);
    denetle("f_80_dallan", gi.sonuc_dallan, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_hata);
    $finish;
  end
endmodule
